shared_adder_sched: RTL and testbench
=====================================

Name: shared_adder_sched

Overview:
- Scheduler and result collector for the shared 1-bit adder datapath (two 2-to-1 muxes selected by m, then a half adder producing s1 = carry, s0 = sum).
- Sits directly upstream and downstream of that datapath. It arbitrates two requesters, AB (operands a, b) and CD (operands c, d), registers the granted operands, and drives m.
- It captures {s1,s0} one cycle later and returns a per-requester registered result with a valid pulse.
- Also counts completed operations.

Parameters:
- CNT_W, 8, width of the completed-operation counter (saturating).

Ports:
- Clock  in  1  rising-edge system clock.
- Resetn  in  1  asynchronous active-low reset.
- req_ab  in  1  AB requester has operands a_in/b_in valid; held high until ack_ab.
- a_in  in  1  AB operand a.
- b_in  in  1  AB operand b.
- req_cd  in  1  CD requester has operands c_in/d_in valid; held high until ack_cd.
- c_in  in  1  CD operand c.
- d_in  in  1  CD operand d.
- ack_ab  out  1  request accepted this cycle (combinational from state/req/pointer).
- ack_cd  out  1  request accepted this cycle.
- m  out  1  mux select to datapath; 0 selects AB, 1 selects CD; registered.
- a  out  1  registered operand a to datapath.
- b  out  1  registered operand b to datapath.
- c  out  1  registered operand c to datapath.
- d  out  1  registered operand d to datapath.
- s1  in  1  datapath carry (combinational from a..d, m).
- s0  in  1  datapath sum bit.
- sum_ab  out  2  last AB result {s1,s0}; holds until next AB completion.
- sum_cd  out  2  last CD result {s1,s0}.
- valid_ab  out  1  one-cycle pulse: sum_ab updated.
- valid_cd  out  1  one-cycle pulse: sum_cd updated.
- busy  out  1  high while in CALC.
- op_count  out  CNT_W  completed operations, saturating at all-ones.

Behaviour:
- Reset (async, Resetn=0): state=IDLE; all outputs zero, specifically m, a, b, c, d, sum_ab, sum_cd, valid_*, busy and op_count; round-robin pointer last=1 (CD last served, so AB wins the first tie). Reset mid-CALC discards the in-flight op: no valid and no count.
- FSM, two states, IDLE and CALC.
- IDLE grant rules:
  - Only req_ab high: grant AB.
  - Only req_cd high: grant CD.
  - Both high: grant the one not equal to last.
  - ack_x = (state==IDLE) & grant_x. At most one ack is high per cycle. No ack when no request.
- At a clock edge with a grant (edge N):
  - Granted pair registered (a<=a_in, b<=b_in for AB; c<=c_in, d<=d_in for CD); the non-granted pair holds its value.
  - m <= 0 for AB, 1 for CD.
  - busy <= 1; state <= CALC.
- CALC lasts exactly one cycle; the datapath settles combinationally. At edge N+1:
  - sum_x <= {s1,s0} for the granted requester; valid_x <= 1 for one cycle.
  - last <= granted id; op_count increments unless all-ones.
  - state <= IDLE; busy <= 0.
- Latency: result visible and valid_x high in the cycle after edge N+1, i.e. 2 cycles after ack. An ack may coincide with the previous op's valid pulse. Throughput: 1 op per 2 cycles.
- m, a, b, c, d are stable throughout CALC. In IDLE, m and the operands hold their last values.
- Requests are sampled only in IDLE. req changes during CALC are ignored. A requester keeping req high after ack is treated as a new request.
- The outputs of this block are all registered except ack_*.
- Results: 2-bit value = a+b (or c+d), range 0..2; no overflow possible.

Test Plan:
- Reset: Resetn=0 with both reqs high -> all outputs 0, no ack. Release -> AB granted first (ack_ab=1, ack_cd=0).
- Single AB, a_in=1 b_in=1 -> ack_ab at cycle N; m=0, a=1, b=1 in CALC; sum_ab=2'b10, valid_ab pulse at N+2; op_count=1.
- Single CD, c_in=1 d_in=0 -> m=1, sum_cd=2'b01, valid_cd one cycle; sum_ab unchanged.
- Both held high for 8 cycles -> grants alternate AB, CD, AB, CD at 2-cycle spacing; m toggles 0,1,0,1; op_count=4.
- Resetn pulsed low during CALC of a CD op -> no valid_cd, sum_cd=0, op_count=0, state IDLE.
- CNT_W=2, 5 back-to-back ops -> op_count saturates at 3.

Source files
------------

// File: rtl/shared_adder_sched.sv
// shared_adder_sched: arbitrates two 1-bit-add requesters (AB, CD) onto a
// shared mux + half-adder datapath and collects its result one cycle later.
//
// Handshake: a requester raises req_x with its operands valid and holds both
// until it sees ack_x. ack_x is combinational and marks the cycle in which
// the operands are taken; the transfer happens at the next rising edge. A req
// still high after that edge is treated as a fresh request. Results come back
// as sum_x with a one-cycle valid_x pulse and no back-pressure.
module shared_adder_sched #(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             req_ab,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             req_cd,
    input  logic             c_in,
    input  logic             d_in,
    output logic             ack_ab,
    output logic             ack_cd,
    output logic             m,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             s1,
    input  logic             s0,
    output logic [1:0]       sum_ab,
    output logic [1:0]       sum_cd,
    output logic             valid_ab,
    output logic             valid_cd,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   last;       // 0: AB served last, 1: CD served last
    logic   grant_ab;
    logic   grant_cd;

    assign state_dbg = (state == CALC);

    // Round-robin grant and next-state; no ack is issued while reset is held.
    always_comb begin
        grant_ab  = 1'b0;
        grant_cd  = 1'b0;
        ack_ab    = 1'b0;
        ack_cd    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                grant_ab = req_ab & (~req_cd | last);
                grant_cd = req_cd & (~req_ab | ~last);
                ack_ab   = Resetn & grant_ab;
                ack_cd   = Resetn & grant_cd;
                if (ack_ab || ack_cd) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on grant; result capture, pointer update and counting
    // at the end of CALC. m doubles as the id of the op in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m        <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
            c        <= 1'b0;
            d        <= 1'b0;
            sum_ab   <= 2'b00;
            sum_cd   <= 2'b00;
            valid_ab <= 1'b0;
            valid_cd <= 1'b0;
            busy     <= 1'b0;
            last     <= 1'b1;
            op_count <= '0;
        end else begin
            valid_ab <= 1'b0;
            valid_cd <= 1'b0;
            if (state == IDLE) begin
                if (ack_ab) begin
                    a    <= a_in;
                    b    <= b_in;
                    m    <= 1'b0;
                    busy <= 1'b1;
                end else if (ack_cd) begin
                    c    <= c_in;
                    d    <= d_in;
                    m    <= 1'b1;
                    busy <= 1'b1;
                end
            end else begin
                if (m) begin
                    sum_cd   <= {s1, s0};
                    valid_cd <= 1'b1;
                end else begin
                    sum_ab   <= {s1, s0};
                    valid_ab <= 1'b1;
                end
                last <= m;
                busy <= 1'b0;
                if (op_count != CNT_MAX) begin
                    op_count <= op_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Testbench for shared_adder_sched: two instances (CNT_W=8 and CNT_W=2) share
// stimulus, each with its own model of the mux + half-adder datapath.
module tb_shared_adder_sched;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    logic req_ab = 1'b0, a_in = 1'b0, b_in = 1'b0;
    logic req_cd = 1'b0, c_in = 1'b0, d_in = 1'b0;

    logic       ack_ab, ack_cd, m, a, b, c, d, s1, s0;
    logic [1:0] sum_ab, sum_cd;
    logic       valid_ab, valid_cd, busy, state_dbg;
    logic [7:0] op_count;

    logic       t_ack_ab, t_ack_cd, t_m, t_a, t_b, t_c, t_d, t_s1, t_s0;
    logic [1:0] t_sum_ab, t_sum_cd;
    logic       t_valid_ab, t_valid_cd, t_busy, t_state_dbg;
    logic [1:0] op_count_sat;

    shared_adder_sched #(.CNT_W(8)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req_ab(req_ab), .a_in(a_in), .b_in(b_in),
        .req_cd(req_cd), .c_in(c_in), .d_in(d_in),
        .ack_ab(ack_ab), .ack_cd(ack_cd),
        .m(m), .a(a), .b(b), .c(c), .d(d),
        .s1(s1), .s0(s0),
        .sum_ab(sum_ab), .sum_cd(sum_cd),
        .valid_ab(valid_ab), .valid_cd(valid_cd),
        .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
    );

    shared_adder_sched #(.CNT_W(2)) dut_sat (
        .Clock(Clock), .Resetn(Resetn),
        .req_ab(req_ab), .a_in(a_in), .b_in(b_in),
        .req_cd(req_cd), .c_in(c_in), .d_in(d_in),
        .ack_ab(t_ack_ab), .ack_cd(t_ack_cd),
        .m(t_m), .a(t_a), .b(t_b), .c(t_c), .d(t_d),
        .s1(t_s1), .s0(t_s0),
        .sum_ab(t_sum_ab), .sum_cd(t_sum_cd),
        .valid_ab(t_valid_ab), .valid_cd(t_valid_cd),
        .busy(t_busy), .op_count(op_count_sat), .state_dbg(t_state_dbg)
    );

    // Shared datapath: 2-to-1 muxes selected by m, then a half adder.
    assign s0   = (m ? c : a) ^ (m ? d : b);
    assign s1   = (m ? c : a) & (m ? d : b);
    assign t_s0 = (t_m ? t_c : t_a) ^ (t_m ? t_d : t_b);
    assign t_s1 = (t_m ? t_c : t_a) & (t_m ? t_d : t_b);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];   // {id (0=AB,1=CD), expected sum}

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model of the scheduler's visible state.
    logic       mdl_calc = 1'b0, mdl_gnt = 1'b0, mdl_last = 1'b1;
    logic       mdl_due_ab = 1'b0, mdl_due_cd = 1'b0;
    logic       mdl_m = 1'b0, mdl_a = 1'b0, mdl_b = 1'b0, mdl_c = 1'b0, mdl_d = 1'b0;
    logic [1:0] mdl_sum_ab = 2'b00, mdl_sum_cd = 2'b00;
    int         mdl_cnt = 0;
    logic       e_ack_ab, e_ack_cd;
    logic [2:0] e_item;
    logic [7:0] e_cnt8;
    logic [7:0] e_cnt2;

    // Monitor: compares on the falling edge, pops the queue on each valid.
    always @(negedge Clock) begin
        if (!Resetn) begin
            check_val("rst_ack_ab", {7'd0, ack_ab}, 8'd0);
            check_val("rst_ack_cd", {7'd0, ack_cd}, 8'd0);
            check_val("rst_regs", {3'd0, m, a, b, c, d}, 8'd0);
            check_val("rst_sums", {4'd0, sum_ab, sum_cd}, 8'd0);
            check_val("rst_flags", {5'd0, valid_ab, valid_cd, busy}, 8'd0);
            check_val("rst_op_count", op_count, 8'd0);
            check_val("rst_op_count_sat", {6'd0, op_count_sat}, 8'd0);
            mdl_calc = 1'b0; mdl_gnt = 1'b0; mdl_last = 1'b1;
            mdl_due_ab = 1'b0; mdl_due_cd = 1'b0;
            mdl_m = 1'b0; mdl_a = 1'b0; mdl_b = 1'b0; mdl_c = 1'b0; mdl_d = 1'b0;
            mdl_sum_ab = 2'b00; mdl_sum_cd = 2'b00; mdl_cnt = 0;
            exp_q.delete();
        end else begin
            e_ack_ab = !mdl_calc && req_ab && (!req_cd || mdl_last);
            e_ack_cd = !mdl_calc && req_cd && (!req_ab || !mdl_last);
            check_val("ack_ab", {7'd0, ack_ab}, {7'd0, e_ack_ab});
            check_val("ack_cd", {7'd0, ack_cd}, {7'd0, e_ack_cd});
            check_val("busy", {7'd0, busy}, {7'd0, mdl_calc});
            check_val("state", {7'd0, state_dbg}, {7'd0, mdl_calc});
            check_val("valid_ab", {7'd0, valid_ab}, {7'd0, mdl_due_ab});
            check_val("valid_cd", {7'd0, valid_cd}, {7'd0, mdl_due_cd});
            check_val("m_operands", {3'd0, m, a, b, c, d},
                      {3'd0, mdl_m, mdl_a, mdl_b, mdl_c, mdl_d});
            if (valid_ab || valid_cd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_valid: got valid_ab=%0b valid_cd=%0b expected none at %0t",
                             valid_ab, valid_cd, $time);
                end else begin
                    e_item = exp_q.pop_front();
                    check_val("result_id", {7'd0, valid_cd}, {7'd0, e_item[2]});
                    if (e_item[2]) begin
                        check_val("sum_cd_result", {6'd0, sum_cd}, {6'd0, e_item[1:0]});
                        mdl_sum_cd = e_item[1:0];
                    end else begin
                        check_val("sum_ab_result", {6'd0, sum_ab}, {6'd0, e_item[1:0]});
                        mdl_sum_ab = e_item[1:0];
                    end
                end
            end
            if (mdl_due_ab || mdl_due_cd) mdl_cnt++;
            e_cnt8 = (mdl_cnt > 255) ? 8'hFF : 8'(mdl_cnt);
            e_cnt2 = (mdl_cnt > 3) ? 8'd3 : 8'(mdl_cnt);
            check_val("sum_ab_hold", {6'd0, sum_ab}, {6'd0, mdl_sum_ab});
            check_val("sum_cd_hold", {6'd0, sum_cd}, {6'd0, mdl_sum_cd});
            check_val("op_count", op_count, e_cnt8);
            check_val("op_count_sat", {6'd0, op_count_sat}, e_cnt2);
            // advance model to the next cycle
            mdl_due_ab = 1'b0;
            mdl_due_cd = 1'b0;
            if (mdl_calc) begin
                mdl_due_ab = !mdl_gnt;
                mdl_due_cd = mdl_gnt;
                mdl_last   = mdl_gnt;
                mdl_calc   = 1'b0;
            end else if (e_ack_ab) begin
                mdl_calc = 1'b1; mdl_gnt = 1'b0; mdl_m = 1'b0;
                mdl_a = a_in; mdl_b = b_in;
            end else if (e_ack_cd) begin
                mdl_calc = 1'b1; mdl_gnt = 1'b1; mdl_m = 1'b1;
                mdl_c = c_in; mdl_d = d_in;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise one request, wait (bounded) for its ack, drop it after the edge.
    task automatic issue(input logic id, input logic x, input logic y, input logic [1:0] exp_sum);
        int n;
        exp_q.push_back({id, exp_sum});
        if (id) begin req_cd = 1'b1; c_in = x; d_in = y; end
        else    begin req_ab = 1'b1; a_in = x; b_in = y; end
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!(id ? ack_cd : ack_ab) && n < 20);
        if (!(id ? ack_cd : ack_ab)) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout: got no ack for id %0d expected ack within 20 cycles", id);
            void'(exp_q.pop_back());
        end
        @(posedge Clock);
        #1;
        req_ab = 1'b0;
        req_cd = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    logic [7:0] ab_bits, cd_bits;

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with both requests high: no ack, everything zero.
        req_ab = 1'b1; a_in = 1'b1; b_in = 1'b0;
        req_cd = 1'b1; c_in = 1'b1; d_in = 1'b1;
        idle_cycles(3);
        Resetn = 1'b1;

        // Both held for 8 cycles: AB first, then alternating every 2 cycles.
        exp_q.push_back({1'b0, 2'b01});
        exp_q.push_back({1'b1, 2'b10});
        exp_q.push_back({1'b0, 2'b01});
        exp_q.push_back({1'b1, 2'b10});
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            ab_bits[i] = ack_ab;
            cd_bits[i] = ack_cd;
        end
        @(posedge Clock);
        #1;
        req_ab = 1'b0;
        req_cd = 1'b0;
        check_val("alt_ack_ab_seq", ab_bits, 8'b0001_0001);
        check_val("alt_ack_cd_seq", cd_bits, 8'b0100_0100);
        idle_cycles(3);
        check_val("alt_op_count", op_count, 8'd4);
        check_val("alt_op_count_sat", {6'd0, op_count_sat}, 8'd3);

        // Single AB 1+1: CALC shows m=0 a=1 b=1, result 2'b10 two cycles after ack.
        issue(1'b0, 1'b1, 1'b1, 2'b10);
        @(negedge Clock);
        check_val("ab_calc_mab", {5'd0, m, a, b}, 8'b0000_0011);
        @(negedge Clock);
        check_val("ab_valid", {7'd0, valid_ab}, 8'd1);
        check_val("ab_sum", {6'd0, sum_ab}, 8'b10);
        check_val("ab_op_count", op_count, 8'd5);
        idle_cycles(2);

        // Single CD 1+0: m=1, sum_cd=01, sum_ab unchanged.
        issue(1'b1, 1'b1, 1'b0, 2'b01);
        @(negedge Clock);
        check_val("cd_calc_mcd", {5'd0, m, c, d}, 8'b0000_0110);
        @(negedge Clock);
        check_val("cd_valid", {7'd0, valid_cd}, 8'd1);
        check_val("cd_sum", {6'd0, sum_cd}, 8'b01);
        check_val("cd_sum_ab_kept", {6'd0, sum_ab}, 8'b10);
        @(negedge Clock);
        check_val("cd_valid_pulse", {7'd0, valid_cd}, 8'd0);
        idle_cycles(2);

        // Reset during CALC of a CD op: op is discarded.
        req_cd = 1'b1; c_in = 1'b1; d_in = 1'b1;
        @(negedge Clock);
        check_val("mid_ack_cd", {7'd0, ack_cd}, 8'd1);
        @(posedge Clock);
        #1;
        req_cd = 1'b0;
        #2;
        Resetn = 1'b0;
        idle_cycles(2);
        Resetn = 1'b1;
        @(negedge Clock);
        check_val("mid_valid_cd", {7'd0, valid_cd}, 8'd0);
        @(negedge Clock);
        check_val("mid_valid_cd_late", {7'd0, valid_cd}, 8'd0);
        check_val("mid_sum_cd", {6'd0, sum_cd}, 8'd0);
        check_val("mid_op_count", op_count, 8'd0);
        check_val("mid_state_idle", {7'd0, state_dbg}, 8'd0);
        idle_cycles(1);

        // Five back-to-back AB ops (req held): narrow counter saturates at 3.
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 2'b01});
        req_ab = 1'b1; a_in = 1'b0; b_in = 1'b1;
        idle_cycles(10);
        req_ab = 1'b0;
        idle_cycles(3);
        check_val("sat_op_count", op_count, 8'd5);
        check_val("sat_op_count_sat", {6'd0, op_count_sat}, 8'd3);

        // Drain check.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clock);
        check_val("queue_drain", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
